hazard_scoreboard: RTL and testbench

Parametrised hazard unit that replaces fixed one-cycle load-use detection with a register scoreboard. It tracks outstanding writes from variable-latency units (loads with memory wait states, multi-cycle mul/div) and sits beside the ID stage. From the scoreboard it generates stall, flush and branch-redirect controls. Trap/MRET handling keeps the existing flush priority, and also clears the scoreboard.

---
 rtl/hazard_scoreboard.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register scoreboard for variable-latency writes, sitting beside ID.
// Tracks outstanding long-latency destinations and derives stall, flush and
// branch-redirect controls from them. Trap/MRET flush the pipe and clear tracking.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating stall-cycle
// counter; otherwise stall_cycles is tied to zero.

module hazard_scoreboard #(
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic              use_rs1_ID,
    input  logic              use_rs2_ID,
    input  logic              RegWrite_ID,
    input  logic              LongLat_ID,
    input  logic              valid_ID,
    input  logic              IsBranch_ID,
    input  logic              IsJAL_ID,
    input  logic              IsJALR_ID,
    input  logic              branch_result,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              trap_taken,
    input  logic              mret_taken,
    output logic              stall,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              flush_EXMEM,
    output logic              flush_MEMWB,
    output logic              branch_taken,
    output logic              sb_full,
    output logic [IF_W-1:0]   inflight,
    output logic [CNT_W-1:0]  stall_cycles
);

    // Full index space; indices 0 and >= NUM_REGS read as never busy.
    localparam int unsigned NIDX = 2 ** REG_AW;

    logic [NUM_REGS-1:1] busy_q, busy_d;
    logic [IF_W-1:0]     inflight_q, inflight_d;

    logic [NIDX-1:0] busy_vec;
    logic [NIDX-1:0] wb_vec;
    logic [NIDX-1:0] eff_vec;

    logic complete;
    logic full_q;
    logic raw, waw, full, hz;
    logic redirect;
    logic rd_trackable;
    logic issue;

    // Widen the busy set to the full index space and apply WB write-through.
    always_comb begin
        busy_vec                 = '0;
        busy_vec[NUM_REGS-1:1]   = busy_q;
        wb_vec                   = wb_valid ? (NIDX'(1) << wb_rd) : '0;
        eff_vec                  = busy_vec & ~wb_vec;
    end

    // Hazard detection and issue/completion qualification.
    always_comb begin
        complete     = wb_valid & (wb_rd != '0) & busy_vec[wb_rd];
        full_q       = (inflight_q == IF_W'(MAX_INFLIGHT));
        raw          = (use_rs1_ID & eff_vec[rs1_ID]) | (use_rs2_ID & eff_vec[rs2_ID]);
        waw          = RegWrite_ID & (rd_ID != '0) & eff_vec[rd_ID];
        full         = LongLat_ID & RegWrite_ID & full_q & ~complete;
        hz           = valid_ID & (raw | waw | full);
        // JAL redirects even while ID is held for a hazard.
        redirect     = valid_ID & ((~hz & ((IsBranch_ID & branch_result) | IsJALR_ID))
                                   | IsJAL_ID);
        // A destination outside the register file has no busy bit to clear later.
        rd_trackable = (32'(rd_ID) < NUM_REGS);
        issue        = valid_ID & RegWrite_ID & LongLat_ID & (rd_ID != '0) & rd_trackable
                       & ~hz & ~trap_taken & ~mret_taken & ~rst;
    end

    // Next busy set: completion clears, issue sets (issue wins on the same register).
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = (busy_q[r] & ~(complete & (wb_rd == REG_AW'(r))))
                        | (issue & (rd_ID == REG_AW'(r)));
        end
        inflight_d = inflight_q + IF_W'(issue) - IF_W'(complete);
    end

    // Scoreboard state; trap and MRET discard all tracking along with the flush.
    always_ff @(posedge clk) begin
        if (rst || trap_taken || mret_taken) begin
            busy_q     <= '0;
            inflight_q <= '0;
        end else begin
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
        end
    end

    // Pipeline controls with priority rst > trap > mret > hazard detection.
    always_comb begin
        stall        = 1'b0;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        flush_EXMEM  = 1'b0;
        flush_MEMWB  = 1'b0;
        branch_taken = 1'b0;
        if (rst) begin
            stall = 1'b0;
        end else if (trap_taken) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            flush_MEMWB = 1'b1;
        end else if (mret_taken) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
        end else begin
            stall        = hz;
            flush_IDEX   = hz;
            branch_taken = redirect;
            flush_IFID   = redirect;
        end
    end

    assign sb_full  = ~rst & full_q;
    assign inflight = inflight_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared against a set-based behavioural model of the scoreboard.

module tb_hazard_scoreboard;

    localparam int unsigned NUM_REGS     = 24;
    localparam int unsigned REG_AW       = 5;
    localparam int unsigned MAX_INFLIGHT = 2;
    localparam int unsigned CNT_W        = 4;
    localparam int unsigned IF_W         = $clog2(MAX_INFLIGHT + 1);
    localparam int          CNT_MAX      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [REG_AW-1:0] rs1_ID = '0, rs2_ID = '0, rd_ID = '0, wb_rd = '0;
    logic use_rs1_ID = 0, use_rs2_ID = 0, RegWrite_ID = 0, LongLat_ID = 0, valid_ID = 0;
    logic IsBranch_ID = 0, IsJAL_ID = 0, IsJALR_ID = 0, branch_result = 0, wb_valid = 0;
    logic trap_taken = 0, mret_taken = 0;
    logic stall, flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB, branch_taken, sb_full;
    logic [IF_W-1:0]  inflight;
    logic [CNT_W-1:0] stall_cycles;
    logic [5:0]       ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_AW      (REG_AW),
        .MAX_INFLIGHT(MAX_INFLIGHT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_ID       (rs1_ID),
        .rs2_ID       (rs2_ID),
        .rd_ID        (rd_ID),
        .use_rs1_ID   (use_rs1_ID),
        .use_rs2_ID   (use_rs2_ID),
        .RegWrite_ID  (RegWrite_ID),
        .LongLat_ID   (LongLat_ID),
        .valid_ID     (valid_ID),
        .IsBranch_ID  (IsBranch_ID),
        .IsJAL_ID     (IsJAL_ID),
        .IsJALR_ID    (IsJALR_ID),
        .branch_result(branch_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .trap_taken   (trap_taken),
        .mret_taken   (mret_taken),
        .stall        (stall),
        .flush_IFID   (flush_IFID),
        .flush_IDEX   (flush_IDEX),
        .flush_EXMEM  (flush_EXMEM),
        .flush_MEMWB  (flush_MEMWB),
        .branch_taken (branch_taken),
        .sb_full      (sb_full),
        .inflight     (inflight),
        .stall_cycles (stall_cycles)
    );

    // Control vector order: stall, IFID, IDEX, EXMEM, MEMWB, branch_taken.
    assign ctl = {stall, flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB, branch_taken};

    // Reference model: set of pending destination registers and a stall tally.
    bit               mbusy [32];
    int               m_scnt = 0;
    int               m_pop;
    bit               e1, e2, ed, m_complete, m_issue, e_hz, e_stall, e_branch, e_sb_full;
    logic [3:0]       e_flush;
    logic [5:0]       e_ctl;
    logic [CNT_W-1:0] e_scnt;

    always_comb begin
        m_pop = 0;
        for (int i = 0; i < 32; i++) if (mbusy[i]) m_pop++;
        e1 = rs1_ID != 0 && int'(rs1_ID) < NUM_REGS && mbusy[rs1_ID] &&
             !(wb_valid && wb_rd == rs1_ID);
        e2 = rs2_ID != 0 && int'(rs2_ID) < NUM_REGS && mbusy[rs2_ID] &&
             !(wb_valid && wb_rd == rs2_ID);
        ed = rd_ID != 0 && int'(rd_ID) < NUM_REGS && mbusy[rd_ID] &&
             !(wb_valid && wb_rd == rd_ID);
        m_complete = wb_valid && wb_rd != 0 && mbusy[wb_rd];
        e_hz = valid_ID && ((use_rs1_ID && e1) || (use_rs2_ID && e2) ||
                            (RegWrite_ID && ed) ||
                            (LongLat_ID && RegWrite_ID && m_pop == MAX_INFLIGHT && !m_complete));
        e_stall  = 1'b0;
        e_branch = 1'b0;
        e_flush  = 4'b0000;
        if (rst) begin
            e_flush = 4'b0000;
        end else if (trap_taken) begin
            e_flush = 4'b1111;
        end else if (mret_taken) begin
            e_flush = 4'b1110;
        end else begin
            e_stall  = e_hz;
            e_branch = valid_ID && (IsJAL_ID ||
                       (!e_hz && ((IsBranch_ID && branch_result) || IsJALR_ID)));
            e_flush  = {e_branch, e_hz, 2'b00};
        end
        e_ctl     = {e_stall, e_flush, e_branch};
        m_issue   = !rst && !trap_taken && !mret_taken && valid_ID && RegWrite_ID &&
                    LongLat_ID && rd_ID != 0 && int'(rd_ID) < NUM_REGS && !e_stall;
        e_sb_full = !rst && m_pop == MAX_INFLIGHT;
`ifdef HAZARD_PERF_CNT_EN
        e_scnt = CNT_W'(m_scnt);
`else
        e_scnt = '0;
`endif
    end

    always @(posedge clk) begin
        if (rst || trap_taken || mret_taken) begin
            for (int i = 0; i < 32; i++) mbusy[i] <= 1'b0;
        end else begin
            if (m_complete) mbusy[wb_rd] <= 1'b0;
            if (m_issue) mbusy[rd_ID] <= 1'b1;
        end
        if (rst) m_scnt <= 0;
        else if (e_stall && m_scnt < CNT_MAX) m_scnt <= m_scnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        rs1_ID = '0; rs2_ID = '0; rd_ID = '0; wb_rd = '0;
        use_rs1_ID = 0; use_rs2_ID = 0; RegWrite_ID = 0; LongLat_ID = 0; valid_ID = 0;
        IsBranch_ID = 0; IsJAL_ID = 0; IsJALR_ID = 0; branch_result = 0; wb_valid = 0;
        trap_taken = 0; mret_taken = 0;
    endtask

    task automatic do_reset();
        clear_id();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_issue(input int r);
        clear_id();
        valid_ID = 1; RegWrite_ID = 1; LongLat_ID = 1; rd_ID = REG_AW'(r);
    endtask

    task automatic test_reset();
        clear_id();
        rst = 1'b1;
        tick();
        tick();
        valid_ID = 1; use_rs1_ID = 1; rs1_ID = 1; IsJAL_ID = 1; trap_taken = 1; wb_valid = 1;
        #2;
        n_checks++;
        if (ctl !== 6'b0 || sb_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got ctl=%b full=%b want 0", ctl, sb_full);
        end
        n_checks++;
        if (inflight !== '0 || stall_cycles !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got inflight=%0d cnt=%0d want 0", inflight, stall_cycles);
        end
        clear_id();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_issue(5);
        #2;
        n_checks++;
        if (ctl !== 6'b0 || inflight !== '0) begin
            n_fail++; $display("FAIL lu_issue: got ctl=%b infl=%0d want 0/0", ctl, inflight);
        end
        tick();
        for (int c = 2; c <= 6; c++) begin
            clear_id();
            valid_ID = 1; use_rs1_ID = 1; rs1_ID = 5; RegWrite_ID = 1; rd_ID = 6;
            if (c == 6) begin wb_valid = 1; wb_rd = 5; end
            #2;
            n_checks++;
            if (ctl !== ((c == 6) ? 6'b000000 : 6'b101000) || inflight !== IF_W'(1)) begin
                n_fail++;
                $display("FAIL lu_cycle%0d: got ctl=%b infl=%0d", c, ctl, inflight);
            end
            tick();
        end
        clear_id();
        #2;
        n_checks++;
        if (inflight !== '0) begin
            n_fail++; $display("FAIL lu_drain: got infl=%0d want 0", inflight);
        end
    endtask

    task automatic test_full();
        do_reset();
        drive_issue(1); #2;
        n_checks++;
        if (ctl !== 6'b0) begin n_fail++; $display("FAIL full_c1: got ctl=%b want 0", ctl); end
        tick();
        drive_issue(2); #2;
        n_checks++;
        if (ctl !== 6'b0 || inflight !== IF_W'(1)) begin
            n_fail++; $display("FAIL full_c2: got ctl=%b infl=%0d", ctl, inflight);
        end
        tick();
        drive_issue(3); #2;
        n_checks++;
        if (ctl !== 6'b101000 || sb_full !== 1'b1 || inflight !== IF_W'(2)) begin
            n_fail++;
            $display("FAIL full_c3: got ctl=%b full=%b infl=%0d", ctl, sb_full, inflight);
        end
        tick();
        drive_issue(3); wb_valid = 1; wb_rd = 1; #2;
        n_checks++;
        if (ctl !== 6'b0 || sb_full !== 1'b1) begin
            n_fail++; $display("FAIL full_c4: got ctl=%b full=%b want 0/1", ctl, sb_full);
        end
        tick();
        clear_id(); valid_ID = 1; use_rs1_ID = 1; rs1_ID = 1; #2;
        n_checks++;
        if (ctl !== 6'b0 || inflight !== IF_W'(2)) begin
            n_fail++; $display("FAIL full_c5: got ctl=%b infl=%0d want 0/2", ctl, inflight);
        end
        tick();
        clear_id(); valid_ID = 1; use_rs2_ID = 1; rs2_ID = 3; #2;
        n_checks++;
        if (ctl !== 6'b101000) begin
            n_fail++; $display("FAIL full_x3_busy: got ctl=%b want 101000", ctl);
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive_issue(7);
        tick();
        for (int c = 2; c <= 4; c++) begin
            clear_id();
            valid_ID = 1; IsBranch_ID = 1; branch_result = 1;
            use_rs1_ID = 1; rs1_ID = 7; use_rs2_ID = 1; rs2_ID = 2;
            if (c == 4) begin wb_valid = 1; wb_rd = 7; end
            #2;
            n_checks++;
            if (ctl !== ((c == 4) ? 6'b010001 : 6'b101000)) begin
                n_fail++; $display("FAIL beq_cycle%0d: got ctl=%b", c, ctl);
            end
            tick();
        end
        drive_issue(8);
        tick();
        clear_id(); valid_ID = 1; IsJAL_ID = 1; RegWrite_ID = 1; rd_ID = 8; #2;
        n_checks++;
        if (ctl !== 6'b111001) begin
            n_fail++; $display("FAIL jal_hazard: got ctl=%b want 111001", ctl);
        end
        tick();
        clear_id(); valid_ID = 1; IsJALR_ID = 1; use_rs1_ID = 1; rs1_ID = 8; #2;
        n_checks++;
        if (ctl !== 6'b101000) begin
            n_fail++; $display("FAIL jalr_hazard: got ctl=%b want 101000", ctl);
        end
        tick();
    endtask

    task automatic test_trap();
        do_reset();
        drive_issue(4);
        tick();
        drive_issue(11); trap_taken = 1; wb_valid = 1; wb_rd = 4; use_rs1_ID = 1; rs1_ID = 4;
        #2;
        n_checks++;
        if (ctl !== 6'b011110) begin
            n_fail++; $display("FAIL trap_flush: got ctl=%b want 011110", ctl);
        end
        tick();
        clear_id(); valid_ID = 1; use_rs1_ID = 1; rs1_ID = 4; use_rs2_ID = 1; rs2_ID = 11; #2;
        n_checks++;
        if (ctl !== 6'b0 || inflight !== '0) begin
            n_fail++; $display("FAIL trap_clear: got ctl=%b infl=%0d want 0/0", ctl, inflight);
        end
        tick();
        drive_issue(10);
        tick();
        clear_id(); mret_taken = 1; valid_ID = 1; IsJAL_ID = 1; #2;
        n_checks++;
        if (ctl !== 6'b011100) begin
            n_fail++; $display("FAIL mret_flush: got ctl=%b want 011100", ctl);
        end
        tick();
        clear_id(); #2;
        n_checks++;
        if (inflight !== '0) begin
            n_fail++; $display("FAIL mret_clear: got infl=%0d want 0", inflight);
        end
        drive_issue(3);
        tick();
        clear_id(); rst = 1; valid_ID = 1; use_rs1_ID = 1; rs1_ID = 3; #2;
        n_checks++;
        if (ctl !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got ctl=%b want 0", ctl);
        end
        tick();
        rst = 0; #2;
        n_checks++;
        if (ctl !== 6'b0 || inflight !== '0) begin
            n_fail++; $display("FAIL rst_mid_clear: got ctl=%b infl=%0d", ctl, inflight);
        end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        drive_issue(9);
        tick();
        for (int c = 2; c <= 4; c++) begin
            drive_issue(9);
            if (c == 4) begin wb_valid = 1; wb_rd = 9; end
            #2;
            n_checks++;
            if (ctl !== ((c == 4) ? 6'b000000 : 6'b101000)) begin
                n_fail++; $display("FAIL waw_cycle%0d: got ctl=%b", c, ctl);
            end
            tick();
        end
        clear_id(); valid_ID = 1; use_rs1_ID = 1; rs1_ID = 9; #2;
        n_checks++;
        if (inflight !== IF_W'(1) || ctl !== 6'b101000) begin
            n_fail++; $display("FAIL waw_reissue: got infl=%0d ctl=%b want 1/101000", inflight, ctl);
        end
        tick();
    endtask

    task automatic test_perf();
        int exp10, exp_sat;
`ifdef HAZARD_PERF_CNT_EN
        exp10 = 10; exp_sat = CNT_MAX;
`else
        exp10 = 0; exp_sat = 0;
`endif
        do_reset();
        drive_issue(5);
        tick();
        for (int i = 0; i < 10; i++) begin
            clear_id(); valid_ID = 1; use_rs1_ID = 1; rs1_ID = 5;
            tick();
        end
        clear_id(); #2;
        n_checks++;
        if (stall_cycles !== CNT_W'(exp10)) begin
            n_fail++; $display("FAIL perf_10: got %0d want %0d", stall_cycles, exp10);
        end
        for (int i = 0; i < 12; i++) begin
            clear_id(); valid_ID = 1; use_rs2_ID = 1; rs2_ID = 5;
            tick();
        end
        clear_id(); #2;
        n_checks++;
        if (stall_cycles !== CNT_W'(exp_sat)) begin
            n_fail++; $display("FAIL perf_sat: got %0d want %0d", stall_cycles, exp_sat);
        end
        rst = 1;
        tick();
        rst = 0; #2;
        n_checks++;
        if (stall_cycles !== '0) begin
            n_fail++; $display("FAIL perf_rst: got %0d want 0", stall_cycles);
        end
        tick();
    endtask

    function automatic logic [REG_AW-1:0] pick_reg();
        int k;
        k = $urandom_range(0, 15);
        if (k < 12) return REG_AW'(k % 5);
        return REG_AW'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            trap_taken    = ($urandom_range(0, 39) == 0);
            mret_taken    = ($urandom_range(0, 39) == 0);
            valid_ID      = ($urandom_range(0, 3) != 0);
            RegWrite_ID   = ($urandom_range(0, 1) == 1);
            LongLat_ID    = ($urandom_range(0, 1) == 1);
            use_rs1_ID    = ($urandom_range(0, 1) == 1);
            use_rs2_ID    = ($urandom_range(0, 1) == 1);
            IsBranch_ID   = ($urandom_range(0, 3) == 0);
            IsJAL_ID      = ($urandom_range(0, 7) == 0);
            IsJALR_ID     = ($urandom_range(0, 7) == 0);
            branch_result = ($urandom_range(0, 1) == 1);
            wb_valid      = ($urandom_range(0, 2) == 0);
            rs1_ID = pick_reg(); rs2_ID = pick_reg(); rd_ID = pick_reg(); wb_rd = pick_reg();
            #2;
            n_checks++;
            if (ctl !== e_ctl) begin
                n_fail++; $display("FAIL rnd_ctl n=%0d: got %b want %b", n, ctl, e_ctl);
            end
            n_checks++;
            if (inflight !== IF_W'(m_pop) || sb_full !== e_sb_full) begin
                n_fail++;
                $display("FAIL rnd_count n=%0d: got infl=%0d full=%b want %0d/%b",
                         n, inflight, sb_full, m_pop, e_sb_full);
            end
            n_checks++;
            if (stall_cycles !== e_scnt) begin
                n_fail++; $display("FAIL rnd_perf n=%0d: got %0d want %0d", n, stall_cycles, e_scnt);
            end
            tick();
        end
        clear_id();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_full();
        test_branch();
        test_trap();
        test_waw();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
